map_ram_port_arbiter: RTL and testbench

- Shares the single map RAM port B (30 rows × 160-bit words, 40 cells × 4 bits) among three requesters:
  - sprite writer: read-modify-write sequences;
  - VGA row fetcher;
  - game-logic cell query (dot/pill/collision lookup).
- Sits between those requesters and the map RAM instance.
- Performs priority arbitration, honours writer locks and prevents starvation.
- Routes the 1-cycle-latency read data back with per-requester valid strobes.

---
 rtl/map_pkg.sv | 27 ++
 rtl/map_arb_starve_ctr.sv | 26 ++
 rtl/map_ram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_map_ram_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared map RAM constants, cell codes and arbitration types.
// Rows are 160-bit words holding 40 cells of 4 bits each.
package map_pkg;

   localparam int ROWS   = 30;
   localparam int WORD_W = 160;
   localparam int ADDR_W = 5;

   typedef enum logic [3:0] {
      CELL_EMPTY  = 4'd0,
      CELL_PACMAN = 4'd4,
      CELL_GHOST  = 4'd5
   } cell_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_WR   = 2'd1,
      OWN_VGA  = 2'd2,
      OWN_Q    = 2'd3
   } owner_t;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/map_arb_starve_ctr.sv
// Saturating count of consecutive denied query cycles; o_boost raises the
// query to top priority once the count reaches LIMIT.
module map_arb_starve_ctr #(
   parameter int LIMIT = 8
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic i_req,
   input  logic i_gnt,
   output logic o_boost
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge CLOCK_50) begin
      if (reset || !i_req || i_gnt)
         r_cnt <= '0;
      else if (r_cnt < CW'(LIMIT))
         r_cnt <= r_cnt + CW'(1);
   end

   assign o_boost = (r_cnt >= CW'(LIMIT));

endmodule

// File: rtl/map_ram_port_arbiter.sv
// Arbitrates map RAM port B between sprite writer, VGA fetch and cell query;
// grant and RAM drive are combinational, read data returns one cycle later.
module map_ram_port_arbiter
   import map_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              wr_req,
   input  logic              wr_lock,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_wren,
   input  logic [WORD_W-1:0] wr_data,
   output logic              wr_gnt,
   output logic              wr_valid,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_valid,
   input  logic              q_req,
   input  logic [ADDR_W-1:0] q_addr,
   output logic              q_gnt,
   output logic              q_valid,
   output logic [WORD_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [WORD_W-1:0] ram_data,
   input  logic [WORD_W-1:0] ram_q,
   output logic              addr_err
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   owner_t            w_owner;
   owner_t            w_rd_owner;
   owner_t            r_owner;
   logic              r_zero;
   logic              r_addr_err;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_addr_ok;
   logic              w_boost;

   map_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .i_req    (q_req),
      .i_gnt    (q_gnt),
      .o_boost  (w_boost)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset)
         r_state <= ST_ARB;
      else
         r_state <= w_state_nxt;
   end

   // Grants are suppressed while reset is held so nothing reaches the RAM.
   always_comb begin
      w_owner     = OWN_NONE;
      w_state_nxt = r_state;
      if (!reset) begin
         if (r_state == ST_LOCKED) begin
            if (wr_req)
               w_owner = OWN_WR;
         end else if (w_boost && q_req) begin
            w_owner = OWN_Q;
         end else if (wr_req) begin
            w_owner = OWN_WR;
         end else if (vga_req) begin
            w_owner = OWN_VGA;
         end else if (q_req) begin
            w_owner = OWN_Q;
         end
         case (r_state)
            ST_ARB:    if (w_owner == OWN_WR && wr_lock) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (!wr_lock) w_state_nxt = ST_ARB;
            default:   w_state_nxt = ST_ARB;
         endcase
      end
   end

   always_comb begin
      w_sel_addr = '0;
      case (w_owner)
         OWN_WR:  w_sel_addr = wr_addr;
         OWN_VGA: w_sel_addr = vga_addr;
         OWN_Q:   w_sel_addr = q_addr;
         default: w_sel_addr = '0;
      endcase
   end

   assign w_addr_ok  = (int'(w_sel_addr) < ROWS);
   assign w_rd_owner = (w_owner == OWN_WR && wr_wren) ? OWN_NONE : w_owner;

   assign wr_gnt   = (w_owner == OWN_WR);
   assign vga_gnt  = (w_owner == OWN_VGA);
   assign q_gnt    = (w_owner == OWN_Q);
   assign ram_addr = (w_owner == OWN_NONE) ? r_ram_addr : (w_addr_ok ? w_sel_addr : '0);
   assign ram_wren = wr_gnt && wr_wren && w_addr_ok;
   assign ram_data = wr_gnt ? wr_data : '0;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_owner    <= OWN_NONE;
         r_zero     <= 1'b0;
         r_addr_err <= 1'b0;
         r_ram_addr <= '0;
      end else begin
         r_owner    <= w_rd_owner;
         r_zero     <= !w_addr_ok;
         r_ram_addr <= ram_addr;
         if (w_owner != OWN_NONE && !w_addr_ok)
            r_addr_err <= 1'b1;
      end
   end

   // A strobe registered before reset must not escape during the reset cycle.
   assign wr_valid  = !reset && (r_owner == OWN_WR);
   assign vga_valid = !reset && (r_owner == OWN_VGA);
   assign q_valid   = !reset && (r_owner == OWN_Q);
   assign rdata     = r_zero ? '0 : ram_q;
   assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_map_ram_port_arbiter.sv
// Randomized and directed bench for map_ram_port_arbiter against a
// cycle-level reference model with its own copy of the map RAM.
module tb_map_ram_port_arbiter;

   localparam int STARVE = 8;

   logic         CLOCK_50 = 1'b0;
   logic         reset;
   logic         wr_req, wr_lock, wr_wren;
   logic [4:0]   wr_addr, vga_addr, q_addr;
   logic [159:0] wr_data;
   logic         vga_req, q_req;
   logic         wr_gnt, wr_valid, vga_gnt, vga_valid, q_gnt, q_valid;
   logic [159:0] rdata, ram_data, ram_q;
   logic [4:0]   ram_addr;
   logic         ram_wren, addr_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [159:0] bmem    [32];
   logic [159:0] ref_mem [32];
   logic         init_ram;

   bit           m_locked, m_err, primed;
   int           m_cnt, m_pend;
   logic [159:0] m_pdat;
   logic [4:0]   m_last;
   logic         s_wr_gnt, s_vga_gnt, s_q_gnt;

   always #10 CLOCK_50 = ~CLOCK_50;

   map_ram_port_arbiter #(.STARVE_LIMIT(STARVE)) dut (
      .CLOCK_50 (CLOCK_50), .reset (reset),
      .wr_req (wr_req), .wr_lock (wr_lock), .wr_addr (wr_addr), .wr_wren (wr_wren),
      .wr_data (wr_data), .wr_gnt (wr_gnt), .wr_valid (wr_valid),
      .vga_req (vga_req), .vga_addr (vga_addr), .vga_gnt (vga_gnt), .vga_valid (vga_valid),
      .q_req (q_req), .q_addr (q_addr), .q_gnt (q_gnt), .q_valid (q_valid),
      .rdata (rdata), .ram_addr (ram_addr), .ram_wren (ram_wren), .ram_data (ram_data),
      .ram_q (ram_q), .addr_err (addr_err)
   );

   // Behavioural single-port RAM with registered read (old data on write).
   always @(posedge CLOCK_50) begin
      if (init_ram) begin
         for (int i = 0; i < 32; i++) bmem[i] <= ref_mem[i];
      end else begin
         if (ram_wren) bmem[ram_addr] <= ram_data;
         ram_q <= bmem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] onehot(input int o);
      return (o == 1) ? 3'b100 : (o == 2) ? 3'b010 : (o == 3) ? 3'b001 : 3'b000;
   endfunction

   function automatic logic [159:0] rnd160();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Compare one cycle at the falling edge, advance the model, return at posedge+1.
   task automatic tick();
      int           own;
      logic [4:0]   a, ea;
      bit           ok, ew;
      @(negedge CLOCK_50);
      s_wr_gnt = wr_gnt; s_vga_gnt = vga_gnt; s_q_gnt = q_gnt;
      if (reset) begin
         check("rst_gnt", {wr_gnt, vga_gnt, q_gnt}, 3'b000);
         check("rst_valid", {wr_valid, vga_valid, q_valid}, 3'b000);
         check("rst_wren", ram_wren, 1'b0);
         if (primed) begin
            check("rst_ram_addr", ram_addr, m_last);
            check("rst_addr_err", addr_err, m_err);
         end
         primed = 1; m_locked = 0; m_cnt = 0; m_pend = 0; m_err = 0; m_last = 0;
      end else begin
         check("valid", {wr_valid, vga_valid, q_valid}, onehot(m_pend));
         if (m_pend != 0) check("rdata", rdata, m_pdat);
         check("addr_err", addr_err, m_err);
         own = 0;
         if (m_locked)                       own = wr_req ? 1 : 0;
         else if (q_req && m_cnt >= STARVE)  own = 3;
         else if (wr_req)                    own = 1;
         else if (vga_req)                   own = 2;
         else if (q_req)                     own = 3;
         a  = (own == 1) ? wr_addr : (own == 2) ? vga_addr : q_addr;
         ok = (a < 5'd30);
         ea = (own == 0) ? m_last : (ok ? a : 5'd0);
         ew = (own == 1) && wr_wren && ok;
         check("gnt", {wr_gnt, vga_gnt, q_gnt}, onehot(own));
         check("ram_addr", ram_addr, ea);
         check("ram_wren", ram_wren, ew);
         if (ew) check("ram_data", ram_data, wr_data);
         m_pend = (own == 0 || (own == 1 && wr_wren)) ? 0 : own;
         m_pdat = ok ? ref_mem[a] : '0;
         if (ew) ref_mem[a] = wr_data;
         if (own != 0 && !ok) m_err = 1;
         m_cnt    = (q_req && own != 3) ? ((m_cnt < STARVE) ? m_cnt + 1 : STARVE) : 0;
         m_locked = m_locked ? bit'(wr_lock) : (own == 1 && wr_lock);
         m_last   = ea;
      end
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic idle();
      wr_req = 0; wr_lock = 0; wr_wren = 0; vga_req = 0; q_req = 0;
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 32; i++) ref_mem[i] = rnd160();
      idle();
      wr_addr = 0; vga_addr = 0; q_addr = 0; wr_data = '0;
      reset = 1; init_ram = 1; primed = 0;
      tick();
      init_ram = 0;
      tick();
      reset = 0;
      tick();

      // Single VGA fetch of row 7.
      vga_req = 1; vga_addr = 7; tick();
      vga_req = 0; tick(); tick();

      // Three-way contention, released in priority order.
      wr_req = 1; wr_addr = 1; vga_req = 1; vga_addr = 2; q_req = 1; q_addr = 3; tick();
      wr_req = 0; tick();
      vga_req = 0; tick();
      q_req = 0; tick();

      // Locked RMW on rows 3 and 5 with VGA waiting.
      vga_req = 1; vga_addr = 9;
      wr_req = 1; wr_lock = 1;
      wr_addr = 3; wr_wren = 0; tick();
      wr_wren = 1; wr_data = rnd160(); tick();
      wr_addr = 5; wr_wren = 0; tick();
      wr_wren = 1; wr_data = rnd160(); tick();
      idle(); vga_req = 1; tick();
      tick();
      check("lock_release_vga", s_vga_gnt, 1'b1);
      idle(); tick();

      // Starvation boost: query wins on cycle STARVE+1.
      q_req = 1; q_addr = 4; vga_req = 1; vga_addr = 6;
      seen = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (s_q_gnt) begin seen = i; break; end
      end
      check("starve_cycle", seen, STARVE + 1);
      tick();
      idle(); tick();

      // Illegal query row.
      q_req = 1; q_addr = 30; tick();
      q_req = 0; tick(); tick();
      check("addr_err_sticky", addr_err, 1'b1);

      // Reset while locked with a writer read in flight.
      wr_req = 1; wr_lock = 1; wr_wren = 0; wr_addr = 2; tick();
      tick();
      idle(); reset = 1; tick();
      reset = 0; tick();
      check("post_rst_addr_err", addr_err, 1'b0);
      vga_req = 1; vga_addr = 11; tick();
      check("post_rst_arb", s_vga_gnt, 1'b1);
      idle(); tick();

      // Randomized traffic under level-held request protocol.
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         if (!wr_req || s_wr_gnt || $urandom_range(0, 9) == 0) begin
            wr_req = 1'($urandom_range(0, 1)); wr_addr = 5'($urandom_range(0, 31));
         end
         if (!vga_req || s_vga_gnt || $urandom_range(0, 9) == 0) begin
            vga_req = 1'($urandom_range(0, 1)); vga_addr = 5'($urandom_range(0, 31));
         end
         if (!q_req || s_q_gnt || $urandom_range(0, 9) == 0) begin
            q_req = 1'($urandom_range(0, 1)); q_addr = 5'($urandom_range(0, 31));
         end
         if ($urandom_range(0, 3) == 0) wr_lock = ~wr_lock;
         wr_wren = 1'($urandom_range(0, 1));
         wr_data = rnd160();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
